// File: rtl/render_sequencer.sv
// Frame sequencer: walks every (light, geometry) slot pair light-major and hands valid geometry to the pixel pipeline.
// Jobs held on obj_valid until obj_ready; processor is stalled via controller_busy for the whole frame.
module render_sequencer #(
  parameter int NUM_GEOMETRY   = 16,
  parameter int NUM_LIGHTS     = 4,
  parameter int GEOMETRY_WIDTH = 32,
  localparam int GA = $clog2(NUM_GEOMETRY),
  localparam int LA = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                      clk_100mhz,
  input  logic                      rst_n,
  input  logic                      inst_valid,
  input  logic                      inst_render,
  input  logic                      mem_ready,
  input  logic [GEOMETRY_WIDTH-1:0] cur_geo,
  output logic                      controller_busy,
  output logic [GA-1:0]             geometry_read_addr,
  output logic [LA-1:0]             light_read_addr,
  output logic                      obj_valid,
  input  logic                      obj_ready,
  output logic [GEOMETRY_WIDTH-1:0] obj_geo,
  output logic [LA-1:0]             obj_light,
  output logic                      frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEM,
    ADDR,
    READ,
    SEND,
    DONE
  } state_t;

  localparam logic [GA-1:0] GEO_MAX   = GA'(NUM_GEOMETRY - 1);
  localparam logic [LA-1:0] LIGHT_MAX = LA'(NUM_LIGHTS - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [GA-1:0]             r_geo_cnt;
  logic [LA-1:0]             r_light_cnt;
  logic [GEOMETRY_WIDTH-1:0] r_obj_geo;
  logic [LA-1:0]             r_obj_light;
  logic                      w_accept;
  logic                      w_advance;
  logic                      w_geo_last;
  logic                      w_pair_last;

  assign w_accept    = (r_state == IDLE) && inst_valid && inst_render;
  assign w_geo_last  = (r_geo_cnt == GEO_MAX);
  assign w_pair_last = w_geo_last && (r_light_cnt == LIGHT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = WAIT_MEM;
      WAIT_MEM: if (mem_ready) w_state_nxt = ADDR;
      ADDR:     w_state_nxt = READ;
      READ: begin
        if (cur_geo[GEOMETRY_WIDTH-1]) begin
          w_state_nxt = SEND;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = w_pair_last ? DONE : ADDR;
        end
      end
      SEND: begin
        if (obj_ready) begin
          w_advance   = 1'b1;
          w_state_nxt = w_pair_last ? DONE : ADDR;
        end
      end
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters double as the read addresses, so they only move on advance and stay put ADDR..SEND.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_geo_cnt   <= '0;
      r_light_cnt <= '0;
      r_obj_geo   <= '0;
      r_obj_light <= '0;
    end else begin
      if (w_accept) begin
        r_geo_cnt   <= '0;
        r_light_cnt <= '0;
      end else if (w_advance) begin
        r_geo_cnt <= r_geo_cnt + 1'b1;
        if (w_geo_last) begin
          r_light_cnt <= w_pair_last ? '0 : r_light_cnt + 1'b1;
        end
      end
      if (r_state == READ) begin
        r_obj_geo   <= cur_geo;
        r_obj_light <= r_light_cnt;
      end
    end
  end

  assign controller_busy    = (r_state != IDLE);
  assign obj_valid          = (r_state == SEND);
  assign frame_done         = (r_state == DONE);
  assign geometry_read_addr = r_geo_cnt;
  assign light_read_addr    = r_light_cnt;
  assign obj_geo            = r_obj_geo;
  assign obj_light          = r_obj_light;

endmodule

// File: tb/tb_render_sequencer.sv
// Bench for render_sequencer: directed frames plus randomized traffic checked against a light-major job list model.
module tb_render_sequencer;

  localparam int NG = 16;
  localparam int NL = 4;
  localparam int GW = 32;

  logic          clk_100mhz = 1'b0;
  logic          rst_n;
  logic          inst_valid;
  logic          inst_render;
  logic          mem_ready;
  logic [GW-1:0] cur_geo;
  logic          controller_busy;
  logic [3:0]    geometry_read_addr;
  logic [1:0]    light_read_addr;
  logic          obj_valid;
  logic          obj_ready;
  logic [GW-1:0] obj_geo;
  logic [1:0]    obj_light;
  logic          frame_done;

  render_sequencer #(
    .NUM_GEOMETRY  (NG),
    .NUM_LIGHTS    (NL),
    .GEOMETRY_WIDTH(GW)
  ) dut (
    .clk_100mhz        (clk_100mhz),
    .rst_n             (rst_n),
    .inst_valid        (inst_valid),
    .inst_render       (inst_render),
    .mem_ready         (mem_ready),
    .cur_geo           (cur_geo),
    .controller_busy   (controller_busy),
    .geometry_read_addr(geometry_read_addr),
    .light_read_addr   (light_read_addr),
    .obj_valid         (obj_valid),
    .obj_ready         (obj_ready),
    .obj_geo           (obj_geo),
    .obj_light         (obj_light),
    .frame_done        (frame_done)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Scene memory with one cycle of read latency.
  logic [GW-1:0] geo_mem [NG];
  always @(posedge clk_100mhz) cur_geo <= geo_mem[geometry_read_addr];

  typedef struct {
    logic [GW-1:0] g;
    logic [1:0]    l;
  } job_t;

  job_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  // mode 0: all valid, 1: only slots 3 and 9 valid, 2: random validity
  task automatic fill_mem(input int mode);
    logic [GW-1:0] d;
    for (int g = 0; g < NG; g++) begin
      d = $urandom;
      case (mode)
        0:       d[GW-1] = 1'b1;
        1:       d[GW-1] = (g == 3) || (g == 9);
        default: d[GW-1] = $urandom_range(1);
      endcase
      geo_mem[g] = d;
    end
  endtask

  // Expected jobs in light-major order; cyc = cycles from WAIT_MEM to DONE with no stalls.
  task automatic build_exp(output int cyc);
    job_t j;
    exp_q.delete();
    cyc = 1;
    for (int l = 0; l < NL; l++) begin
      for (int g = 0; g < NG; g++) begin
        if (geo_mem[g][GW-1]) begin
          j.g = geo_mem[g];
          j.l = l[1:0];
          exp_q.push_back(j);
          cyc += 3;
        end else begin
          cyc += 2;
        end
      end
    end
  endtask

  task automatic issue_render();
    inst_valid  = 1'b1;
    inst_render = 1'b1;
    step();
    inst_valid  = 1'b0;
    inst_render = 1'b0;
    chk("busy_after_accept", controller_busy, 1);
  endtask

  task automatic scan(input int ready_pct, input bit rnd, input int exp_cyc, input bit b2b);
    int            cyc;
    int            extra;
    bit            done;
    bit            stall;
    logic [GW-1:0] pg;
    logic [1:0]    pl;
    logic [3:0]    pa;
    job_t          j;
    cyc   = 0;
    extra = 0;
    done  = 0;
    stall = 0;
    pg    = '0;
    pl    = '0;
    pa    = '0;
    while (cyc < 5000 && !done) begin
      if (stall) begin
        chk("stall_valid", obj_valid, 1);
        chk("stall_geo", obj_geo, pg);
        chk("stall_light", obj_light, pl);
        chk("stall_addr", geometry_read_addr, pa);
      end
      if (frame_done) begin
        done = 1;
        chk("queue_empty_at_done", exp_q.size(), 0);
        if (exp_cyc >= 0) chk("frame_cycles", cyc, exp_cyc);
        chk("busy_at_done", controller_busy, 1);
        inst_valid = 1'b0;
        mem_ready  = 1'b1;
        obj_ready  = 1'b0;
        step();
        chk("busy_after_done", controller_busy, 0);
        chk("done_pulse_len", frame_done, 0);
        if (b2b) begin
          issue_render();
        end else begin
          step();
          chk("no_restart", controller_busy, 0);
        end
      end else begin
        chk("busy_during_frame", controller_busy, 1);
        obj_ready = ($urandom_range(99) < ready_pct);
        if (rnd) begin
          mem_ready   = $urandom_range(1);
          inst_valid  = $urandom_range(1);
          inst_render = $urandom_range(1);
        end
        if (obj_valid && obj_ready) begin
          if (exp_q.size() == 0) begin
            extra++;
          end else begin
            j = exp_q.pop_front();
            chk("job_geo", obj_geo, j.g);
            chk("job_light", obj_light, j.l);
            chk("job_light_addr", light_read_addr, j.l);
          end
        end
        stall = obj_valid && !obj_ready;
        pg    = obj_geo;
        pl    = obj_light;
        pa    = geometry_read_addr;
        step();
        cyc++;
      end
    end
    chk("frame_finished", done, 1);
    chk("extra_jobs", extra, 0);
    inst_valid  = 1'b0;
    inst_render = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, controller_busy, 0);
    chk({tag, "_obj_valid"}, obj_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_obj_geo"}, obj_geo, 0);
    chk({tag, "_obj_light"}, obj_light, 0);
    chk({tag, "_geo_addr"}, geometry_read_addr, 0);
    chk({tag, "_light_addr"}, light_read_addr, 0);
  endtask

  initial begin
    int c;
    int seen;
    logic [GW-1:0] hg;
    logic [1:0]    hl;
    logic [3:0]    ha;
    rst_n       = 1'b0;
    inst_valid  = 1'b0;
    inst_render = 1'b0;
    mem_ready   = 1'b1;
    obj_ready   = 1'b0;
    fill_mem(0);
    #2;
    check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full frame, everything valid, no backpressure.
    fill_mem(0);
    build_exp(c);
    chk("full_frame_model_cycles", c, 1 + NL * NG * 3);
    issue_render();
    scan(100, 0, c, 0);

    // Sparse scene: slots 3 and 9 only.
    fill_mem(1);
    build_exp(c);
    chk("sparse_job_count", exp_q.size(), 2 * NL);
    issue_render();
    scan(100, 0, c, 0);

    // Non-render instruction and stray render bit in IDLE.
    inst_valid  = 1'b1;
    inst_render = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_nonrender_busy", controller_busy, 0);
    end
    inst_valid  = 1'b0;
    inst_render = 1'b1;
    step();
    chk("idle_render_no_valid_busy", controller_busy, 0);
    inst_render = 1'b0;

    // Memory not ready for 20 cycles.
    fill_mem(2);
    build_exp(c);
    mem_ready = 1'b0;
    issue_render();
    for (int i = 0; i < 20; i++) begin
      chk("wait_mem_busy", controller_busy, 1);
      chk("wait_mem_obj_valid", obj_valid, 0);
      chk("wait_mem_geo_addr", geometry_read_addr, 0);
      chk("wait_mem_light_addr", light_read_addr, 0);
      step();
    end
    mem_ready = 1'b1;
    scan(70, 1, -1, 0);

    // Backpressure: hold obj_ready low for 10 cycles on the first job.
    fill_mem(0);
    build_exp(c);
    obj_ready = 1'b0;
    issue_render();
    seen = 0;
    while (!obj_valid && seen < 100) begin
      step();
      seen++;
    end
    chk("first_job_presented", obj_valid, 1);
    hg = obj_geo;
    hl = obj_light;
    ha = geometry_read_addr;
    chk("held_job_geo", hg, geo_mem[0]);
    chk("held_job_light", hl, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", obj_valid, 1);
      chk("hold_geo", obj_geo, hg);
      chk("hold_light", obj_light, hl);
      chk("hold_addr", geometry_read_addr, ha);
    end
    scan(100, 0, -1, 0);

    // Reset during job 5, then a clean frame.
    fill_mem(0);
    build_exp(c);
    obj_ready = 1'b1;
    issue_render();
    seen = 0;
    for (int i = 0; i < 200 && seen < 5; i++) begin
      if (obj_valid) seen++;
      if (seen < 5) step();
    end
    chk("reached_job5", seen, 5);
    chk("job5_light", obj_light, 0);
    chk("job5_geo", obj_geo, geo_mem[4]);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold_no_done", frame_done, 0);
    end
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset_idle");
    fill_mem(0);
    build_exp(c);
    obj_ready = 1'b0;
    issue_render();
    scan(100, 0, c, 0);

    // Back-to-back frames, render accepted the cycle after DONE.
    fill_mem(2);
    build_exp(c);
    issue_render();
    scan(100, 0, c, 1);
    build_exp(c);
    scan(100, 0, c, 0);

    // Randomized frames with backpressure and stray inputs.
    for (int f = 0; f < 3; f++) begin
      fill_mem(2);
      build_exp(c);
      mem_ready = 1'b1;
      issue_render();
      scan(60, 1, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/render_sequencer.md
RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 Parameter NUM_GEOMETRY, default 16: number of geometry slots scanned per frame (power of 2, >=2).
REQ-002 Parameter NUM_LIGHTS, default 4: number of light slots scanned per frame (power of 2, >=1).
REQ-003 Parameter GEOMETRY_WIDTH, default 32: geometry record width; bit GEOMETRY_WIDTH-1 is the slot-valid flag.
REQ-004 Port clk_100mhz, input, 1: the single clock; all state on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port inst_valid, input, 1: processor presents an executed instruction this cycle.
REQ-007 Port inst_render, input, 1: presented instruction is a render command.
REQ-008 Port mem_ready, input, 1: scene memories are consistent and readable.
REQ-009 Port cur_geo, input, GEOMETRY_WIDTH: geometry record at geometry_read_addr, valid one cycle after the address.
REQ-010 Port controller_busy, output, 1: sequencer is rendering; processor stalls while high.
REQ-011 Port geometry_read_addr, output, $clog2(NUM_GEOMETRY): geometry slot being read.
REQ-012 Port light_read_addr, output, $clog2(NUM_LIGHTS): light slot being read.
REQ-013 Port obj_valid, output, 1: obj_geo/obj_light hold a job for the pixel pipeline.
REQ-014 Port obj_ready, input, 1: pixel pipeline accepts the job this cycle.
REQ-015 Port obj_geo, output, GEOMETRY_WIDTH: captured geometry record.
REQ-016 Port obj_light, output, $clog2(NUM_LIGHTS): light index paired with obj_geo.
REQ-017 Port frame_done, output, 1: one-cycle pulse when a frame finishes.

Function
REQ-018 FSM states: IDLE, WAIT_MEM, ADDR, READ, SEND, DONE.
REQ-019 IDLE: inst_valid && inst_render -> WAIT_MEM, geometry and light counters cleared to 0; all other inputs ignored.
REQ-020 controller_busy SHALL be high exactly in WAIT_MEM, ADDR, READ, SEND, DONE, i.e. from the cycle after acceptance through the DONE cycle.
REQ-021 inst_valid while not IDLE SHALL be ignored (no queueing, no restart).
REQ-022 WAIT_MEM: stay while mem_ready=0; mem_ready=1 -> ADDR.
REQ-023 geometry_read_addr and light_read_addr SHALL be registered copies of the counters, stable from ADDR through SEND of the same pair.
REQ-024 ADDR -> READ unconditionally (one-cycle memory read latency).
REQ-025 READ: cur_geo captured into obj_geo and counter light index into obj_light; flag bit 1 -> SEND, flag bit 0 -> advance (REQ-027) without SEND.
REQ-026 SEND: obj_valid=1; obj_geo/obj_light held stable until obj_ready=1; on obj_valid && obj_ready advance (REQ-027). obj_ready outside SEND ignored.
REQ-027 Advance: geometry counter +1; at NUM_GEOMETRY-1 it wraps to 0 and light counter +1; if both counters were at maximum -> DONE, else -> ADDR.
REQ-028 Pair order: light-major, geometry-minor; every (light, geometry) pair visited exactly once per frame.
REQ-029 DONE: frame_done=1 for exactly this cycle, then IDLE; controller_busy low from the following cycle.
REQ-030 A render instruction presented in the cycle after DONE SHALL be accepted normally.
REQ-031 mem_ready falling after WAIT_MEM SHALL not affect the scan.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, counters 0, controller_busy 0, obj_valid 0, frame_done 0, obj_geo 0, obj_light 0, both read addresses 0, regardless of state.
REQ-033 Reset mid-frame SHALL abandon the frame with no frame_done pulse; a job presented on obj_valid is withdrawn.
REQ-034 After rst_n rises, the first rising edge SHALL evaluate IDLE transitions.

Verification
REQ-035 All slots flagged valid, obj_ready tied 1, mem_ready 1 -> exactly NUM_LIGHTS*NUM_GEOMETRY=64 jobs in light-major order, one frame_done, busy high from cycle 1 to the frame_done cycle.
REQ-036 Only geometry slots 3 and 9 valid, NUM_LIGHTS=4 -> 8 jobs: (l0,g3),(l0,g9),(l1,g3)...(l3,g9); frame_done once.
REQ-037 obj_ready held 0 for 10 cycles during SEND -> obj_valid stays 1, obj_geo/obj_light/addresses unchanged, no job lost or duplicated.
REQ-038 Render instruction with mem_ready=0 for 20 cycles -> busy=1, addresses 0, no obj_valid until mem_ready rises.
REQ-039 rst_n pulsed low during job 5 -> all outputs 0 same cycle, no frame_done; next render instruction produces a complete frame from (l0,g0).
REQ-040 Non-render instruction in IDLE, and render instruction while busy -> no state change, busy unaffected, frame count unchanged.
